// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response bundle.
// master modport: issues req + payload, receives addr_ok/data_ok/rdata.
// slave modport : accepts req + payload, returns addr_ok/data_ok/rdata.
interface sram_req_arbiter_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 2;

  logic              req;
  logic              wr;
  logic [SIZE_W-1:0] size;
  logic [ADDR_W-1:0] addr;
  logic [STRB_W-1:0] wstrb;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// Two-master arbiter merging SRAM-like masters m0/m1 onto one slave port s.
// An in-order ID FIFO routes each slave response back to its issuing master.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority m0 > m1.
// Ports:
//   aclk, aresetn    clock, synchronous active-low reset
//   m0, m1           slave-side bundles facing the two masters
//   s                master-side bundle facing the downstream slave
//   busy_o           outstanding-transaction FIFO not empty (registered)
//   err_orphan_o     sticky: response arrived with no outstanding transaction
module sram_req_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  sram_req_arbiter_if.slave   m0,
  sram_req_arbiter_if.slave   m1,
  sram_req_arbiter_if.master  s,
  output logic                busy_o,
  output logic                err_orphan_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [DEPTH-1:0] id_q, id_d;
  logic             lock_q, lock_d;
  logic             lock_id_q, lock_id_d;
  logic             busy_q, busy_d;
  logic             orphan_q, orphan_d;
`ifdef SRAM_ARB_RR_EN
  logic             last_q, last_d;
`endif

  logic grant_c;
  logic gnt_req_c;
  logic full_c;
  logic empty_c;
  logic push_c;
  logic pop_c;
  logic head_c;

  // FIFO status from the extra wrap bit of each pointer
  assign empty_c = (wptr_q == rptr_q);
  assign full_c  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_c  = id_q[rptr_q[AW-1:0]];

  // Grant selection; a stalled request keeps its grant until accepted
  always_comb begin
    grant_c = 1'b0;
    if (lock_q) begin
      grant_c = lock_id_q;
    end else if (m0.req && m1.req) begin
`ifdef SRAM_ARB_RR_EN
      grant_c = ~last_q;
`else
      grant_c = 1'b0;
`endif
    end else if (m1.req) begin
      grant_c = 1'b1;
    end
  end

  // Request mux towards the slave
  always_comb begin
    gnt_req_c = grant_c ? m1.req : m0.req;
    s.req     = gnt_req_c && !full_c && aresetn;
    s.wr      = m0.wr;
    s.size    = m0.size;
    s.addr    = m0.addr;
    s.wstrb   = m0.wstrb;
    s.wdata   = m0.wdata;
    if (grant_c) begin
      s.wr    = m1.wr;
      s.size  = m1.size;
      s.addr  = m1.addr;
      s.wstrb = m1.wstrb;
      s.wdata = m1.wdata;
    end
  end

  assign push_c = s.req && s.addr_ok;
  assign pop_c  = s.data_ok && !empty_c;

  // Accept and response routing back to the masters
  always_comb begin
    m0.addr_ok = push_c && !grant_c;
    m1.addr_ok = push_c && grant_c;
    m0.data_ok = pop_c && !head_c;
    m1.data_ok = pop_c && head_c;
    m0.rdata   = s.rdata;
    m1.rdata   = s.rdata;
  end

  // Next-state: ID FIFO, lock, arbitration history, status flags
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    id_d      = id_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    orphan_d  = orphan_q;
`ifdef SRAM_ARB_RR_EN
    last_d    = last_q;
`endif
    if (push_c) begin
      id_d[wptr_q[AW-1:0]] = grant_c;
      wptr_d               = wptr_q + PW'(1);
      lock_d               = 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_d               = grant_c;
`endif
    end else if (s.req) begin
      lock_d    = 1'b1;
      lock_id_d = grant_c;
    end
    if (pop_c) begin
      rptr_d = rptr_q + PW'(1);
    end
    if (s.data_ok && empty_c) begin
      orphan_d = 1'b1;
    end
    busy_d = (wptr_d != rptr_d);
  end

  // State registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      id_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      busy_q    <= 1'b0;
      orphan_q  <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      id_q      <= id_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      busy_q    <= busy_d;
      orphan_q  <= orphan_d;
`ifdef SRAM_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign busy_o       = busy_q;
  assign err_orphan_o = orphan_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter (DEPTH=4): directed vector table,
// hand sequences for orphan/reset, then randomized traffic against a
// queue-based reference model. Honours SRAM_ARB_RR_EN like the design.
module tb_sram_req_arbiter;
  localparam int unsigned DEPTH = 4;

  logic aclk;
  logic aresetn;
  logic busy;
  logic err_orphan;

  sram_req_arbiter_if m0_bus ();
  sram_req_arbiter_if m1_bus ();
  sram_req_arbiter_if s_bus ();

  sram_req_arbiter #(.DEPTH(DEPTH)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .m0           (m0_bus),
    .m1           (m1_bus),
    .s            (s_bus),
    .busy_o       (busy),
    .err_orphan_o (err_orphan)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int q[$];
  bit m_lock, m_lock_id, m_orphan;
`ifdef SRAM_ARB_RR_EN
  bit m_last;
`endif

  function automatic void model_reset();
    q.delete();
    m_lock = 0; m_lock_id = 0; m_orphan = 0;
`ifdef SRAM_ARB_RR_EN
    m_last = 1;
`endif
  endfunction

  function automatic bit model_grant(bit r0, bit r1);
    if (m_lock) return m_lock_id;
    if (r0 && r1) begin
`ifdef SRAM_ARB_RR_EN
      return (m_last == 1'b1) ? 1'b0 : 1'b1;
`else
      return 1'b0;
`endif
    end
    return (r1 && !r0);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit m0r; logic [31:0] a0; bit m1r; logic [31:0] a1;
    bit aok; bit dok; logic [31:0] rd;
    bit e_sreq; logic [31:0] e_addr;
    bit e_a0; bit e_a1; bit e_d0; bit e_d1; bit e_busy;
  } vec_t;

  function automatic vec_t mk(bit m0r, logic [31:0] a0, bit m1r, logic [31:0] a1,
                              bit aok, bit dok, logic [31:0] rd,
                              bit e_sreq, logic [31:0] e_addr,
                              bit e_a0, bit e_a1, bit e_d0, bit e_d1, bit e_busy);
    vec_t v;
    v.m0r = m0r; v.a0 = a0; v.m1r = m1r; v.a1 = a1;
    v.aok = aok; v.dok = dok; v.rd = rd;
    v.e_sreq = e_sreq; v.e_addr = e_addr;
    v.e_a0 = e_a0; v.e_a1 = e_a1; v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_busy = e_busy;
    return v;
  endfunction

  vec_t tbl[28];

  task automatic idle_inputs();
    m0_bus.req = 0; m0_bus.wr = 0; m0_bus.size = 2'd2; m0_bus.addr = '0;
    m0_bus.wstrb = 4'hF; m0_bus.wdata = '0;
    m1_bus.req = 0; m1_bus.wr = 1; m1_bus.size = 2'd2; m1_bus.addr = '0;
    m1_bus.wstrb = 4'h3; m1_bus.wdata = '0;
    s_bus.addr_ok = 0; s_bus.data_ok = 0; s_bus.rdata = 32'h0;
  endtask

  // Drives one directed cycle of m0-only traffic with slave handshake bits
  task automatic m0_cycle(input bit req, input logic [31:0] addr, input bit aok, input bit dok);
    @(negedge aclk);
    idle_inputs();
    m0_bus.req = req; m0_bus.addr = addr; m0_bus.wdata = ~addr;
    s_bus.addr_ok = aok; s_bus.data_ok = dok; s_bus.rdata = 32'hC0DE_0000 ^ addr;
    #1;
  endtask

  // random master state
  bit          p_pend [2];
  bit          p_wr   [2];
  logic [1:0]  p_size [2];
  logic [31:0] p_addr [2];
  logic [3:0]  p_strb [2];
  logic [31:0] p_data [2];

  initial begin
    aresetn = 1'b0;
    idle_inputs();

    // reset, then reset-state checks
    repeat (2) @(negedge aclk);
    m0_bus.req = 1; m0_bus.addr = 32'h1234;
    #1;
    chk("rst s_req", 32'(s_bus.req), 0);
    chk("rst m0_addr_ok", 32'(m0_bus.addr_ok), 0);
    chk("rst m0_data_ok", 32'(m0_bus.data_ok), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst err_orphan", 32'(err_orphan), 0);
    @(negedge aclk);
    idle_inputs();
    aresetn = 1'b1;

    // solo read
    tbl[0]  = mk(1, 32'h1000, 0, 0, 1, 0, 0,            1, 32'h1000, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0,        0, 0, 0, 0, 0,            0, 0,        0, 0, 0, 0, 1);
    tbl[2]  = mk(0, 0,        0, 0, 0, 0, 0,            0, 0,        0, 0, 0, 0, 1);
    tbl[3]  = mk(0, 0,        0, 0, 0, 1, 32'hDEADBEEF, 0, 0,        0, 0, 1, 0, 1);
    tbl[4]  = mk(0, 0,        0, 0, 0, 0, 0,            0, 0,        0, 0, 0, 0, 0);
    // lock hold: m1 stalled 4 cycles, m0 joins
    tbl[5]  = mk(0, 0,        1, 32'h2000, 0, 0, 0, 1, 32'h2000, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 32'h3000, 1, 32'h2000, 0, 0, 0, 1, 32'h2000, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 32'h3000, 1, 32'h2000, 0, 0, 0, 1, 32'h2000, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 32'h3000, 1, 32'h2000, 0, 0, 0, 1, 32'h2000, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 32'h3000, 1, 32'h2000, 1, 0, 0, 1, 32'h2000, 0, 1, 0, 0, 0);
    tbl[10] = mk(1, 32'h3000, 0, 0,        1, 0, 0, 1, 32'h3000, 1, 0, 0, 0, 1);
    // contention with simultaneous push/pop at occupancy 2, then drain
`ifdef SRAM_ARB_RR_EN
    tbl[11] = mk(1, 32'h4000, 1, 32'h5000, 1, 1, 32'h11, 1, 32'h5000, 0, 1, 0, 1, 1);
    tbl[12] = mk(1, 32'h4000, 1, 32'h5000, 1, 1, 32'h22, 1, 32'h4000, 1, 0, 1, 0, 1);
    tbl[13] = mk(1, 32'h4000, 1, 32'h5000, 1, 1, 32'h33, 1, 32'h5000, 0, 1, 0, 1, 1);
    tbl[14] = mk(1, 32'h4000, 1, 32'h5000, 1, 1, 32'h44, 1, 32'h4000, 1, 0, 1, 0, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 1, 32'h55, 0, 0, 0, 0, 0, 1, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 1, 32'h66, 0, 0, 0, 0, 1, 0, 1);
`else
    tbl[11] = mk(1, 32'h4000, 1, 32'h5000, 1, 1, 32'h11, 1, 32'h4000, 1, 0, 0, 1, 1);
    tbl[12] = mk(1, 32'h4000, 1, 32'h5000, 1, 1, 32'h22, 1, 32'h4000, 1, 0, 1, 0, 1);
    tbl[13] = mk(1, 32'h4000, 1, 32'h5000, 1, 1, 32'h33, 1, 32'h4000, 1, 0, 1, 0, 1);
    tbl[14] = mk(1, 32'h4000, 1, 32'h5000, 1, 1, 32'h44, 1, 32'h4000, 1, 0, 1, 0, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 1, 32'h55, 0, 0, 0, 0, 1, 0, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 1, 32'h66, 0, 0, 0, 0, 1, 0, 1);
`endif
    // fill FIFO with IDs 0,1,1,0 then hit full
    tbl[17] = mk(1, 32'h6000, 0, 0,        1, 0, 0, 1, 32'h6000, 1, 0, 0, 0, 0);
    tbl[18] = mk(0, 0,        1, 32'h7000, 1, 0, 0, 1, 32'h7000, 0, 1, 0, 0, 1);
    tbl[19] = mk(0, 0,        1, 32'h7004, 1, 0, 0, 1, 32'h7004, 0, 1, 0, 0, 1);
    tbl[20] = mk(1, 32'h6004, 0, 0,        1, 0, 0, 1, 32'h6004, 1, 0, 0, 0, 1);
    tbl[21] = mk(1, 32'h6008, 0, 0,        1, 0, 0, 0, 0,        0, 0, 0, 0, 1);
    tbl[22] = mk(1, 32'h6008, 0, 0,        0, 1, 32'hA1, 0, 0,        0, 0, 1, 0, 1);
    tbl[23] = mk(1, 32'h6008, 0, 0,        0, 1, 32'hA2, 1, 32'h6008, 0, 0, 0, 1, 1);
    tbl[24] = mk(1, 32'h6008, 0, 0,        1, 1, 32'hA3, 1, 32'h6008, 1, 0, 0, 1, 1);
    tbl[25] = mk(0, 0, 0, 0, 0, 1, 32'hA4, 0, 0, 0, 0, 1, 0, 1);
    tbl[26] = mk(0, 0, 0, 0, 0, 1, 32'hA5, 0, 0, 0, 0, 1, 0, 1);
    tbl[27] = mk(0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 28; i++) begin
      @(negedge aclk);
      idle_inputs();
      m0_bus.req = tbl[i].m0r; m0_bus.addr = tbl[i].a0; m0_bus.wdata = ~tbl[i].a0;
      m1_bus.req = tbl[i].m1r; m1_bus.addr = tbl[i].a1; m1_bus.wdata = tbl[i].a1 + 32'd1;
      s_bus.addr_ok = tbl[i].aok; s_bus.data_ok = tbl[i].dok; s_bus.rdata = tbl[i].rd;
      #1;
      chk($sformatf("v%0d s_req", i), 32'(s_bus.req), 32'(tbl[i].e_sreq));
      if (tbl[i].e_sreq) chk($sformatf("v%0d s_addr", i), s_bus.addr, tbl[i].e_addr);
      chk($sformatf("v%0d m0_addr_ok", i), 32'(m0_bus.addr_ok), 32'(tbl[i].e_a0));
      chk($sformatf("v%0d m1_addr_ok", i), 32'(m1_bus.addr_ok), 32'(tbl[i].e_a1));
      chk($sformatf("v%0d m0_data_ok", i), 32'(m0_bus.data_ok), 32'(tbl[i].e_d0));
      chk($sformatf("v%0d m1_data_ok", i), 32'(m1_bus.data_ok), 32'(tbl[i].e_d1));
      chk($sformatf("v%0d m0_rdata", i), m0_bus.rdata, tbl[i].rd);
      chk($sformatf("v%0d m1_rdata", i), m1_bus.rdata, tbl[i].rd);
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d err_orphan", i), 32'(err_orphan), 0);
    end

    // orphan response with FIFO empty
    m0_cycle(0, 0, 0, 1);
    chk("orphan m0_data_ok", 32'(m0_bus.data_ok), 0);
    chk("orphan m1_data_ok", 32'(m1_bus.data_ok), 0);
    m0_cycle(0, 0, 0, 0);
    chk("orphan sticky set", 32'(err_orphan), 1);
    m0_cycle(0, 0, 0, 0);
    chk("orphan sticky hold", 32'(err_orphan), 1);

    // reset with 3 outstanding transactions
    for (int k = 0; k < 3; k++) begin
      m0_cycle(1, 32'h8000 + 32'(k * 4), 1, 0);
      chk($sformatf("pre-rst accept %0d", k), 32'(m0_bus.addr_ok), 1);
    end
    m0_cycle(1, 32'h9000, 0, 0);
    aresetn = 1'b0;
    #1;
    chk("mid-rst s_req", 32'(s_bus.req), 0);
    m0_cycle(0, 0, 0, 0);
    aresetn = 1'b1;
    #1;
    chk("post-rst busy", 32'(busy), 0);
    chk("post-rst err_orphan", 32'(err_orphan), 0);
    m0_cycle(0, 0, 0, 1);
    chk("late resp m0_data_ok", 32'(m0_bus.data_ok), 0);
    chk("late resp m1_data_ok", 32'(m1_bus.data_ok), 0);
    m0_cycle(0, 0, 0, 0);
    chk("late resp orphan", 32'(err_orphan), 1);

    // randomized traffic against the reference model
    @(negedge aclk);
    idle_inputs();
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
    for (int m = 0; m < 2; m++) p_pend[m] = 0;

    for (int c = 0; c < 3000; c++) begin
      bit rst_now, aok, dok, g, e_sreq, was_empty;
      bit e_aok [2];
      bit e_dok [2];
      logic [31:0] rd;
      @(negedge aclk);
      for (int m = 0; m < 2; m++) begin
        if (!p_pend[m] && ($urandom_range(0, 2) == 0)) begin
          p_pend[m] = 1;
          p_wr[m]   = 1'($urandom_range(0, 1));
          p_size[m] = 2'($urandom_range(0, 2));
          p_addr[m] = $urandom;
          p_strb[m] = 4'($urandom);
          p_data[m] = $urandom;
        end
      end
      rst_now = ($urandom_range(0, 199) != 0);
      aok = ($urandom_range(0, 3) != 0);
      dok = (q.size() != 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      rd  = $urandom;
      aresetn = rst_now;
      m0_bus.req = p_pend[0]; m0_bus.wr = p_wr[0]; m0_bus.size = p_size[0];
      m0_bus.addr = p_addr[0]; m0_bus.wstrb = p_strb[0]; m0_bus.wdata = p_data[0];
      m1_bus.req = p_pend[1]; m1_bus.wr = p_wr[1]; m1_bus.size = p_size[1];
      m1_bus.addr = p_addr[1]; m1_bus.wstrb = p_strb[1]; m1_bus.wdata = p_data[1];
      s_bus.addr_ok = aok; s_bus.data_ok = dok; s_bus.rdata = rd;
      #1;
      g      = model_grant(p_pend[0], p_pend[1]);
      e_sreq = p_pend[g] && (q.size() < DEPTH) && rst_now;
      was_empty = (q.size() == 0);
      for (int m = 0; m < 2; m++) begin
        e_aok[m] = e_sreq && aok && (int'(g) == m);
        e_dok[m] = dok && !was_empty && (q[0] == m);
      end
      chk("rnd s_req", 32'(s_bus.req), 32'(e_sreq));
      if (e_sreq) begin
        chk("rnd s_addr", s_bus.addr, p_addr[g]);
        chk("rnd s_wr", 32'(s_bus.wr), 32'(p_wr[g]));
        chk("rnd s_size", 32'(s_bus.size), 32'(p_size[g]));
        chk("rnd s_wstrb", 32'(s_bus.wstrb), 32'(p_strb[g]));
        chk("rnd s_wdata", s_bus.wdata, p_data[g]);
      end
      chk("rnd m0_addr_ok", 32'(m0_bus.addr_ok), 32'(e_aok[0]));
      chk("rnd m1_addr_ok", 32'(m1_bus.addr_ok), 32'(e_aok[1]));
      chk("rnd m0_data_ok", 32'(m0_bus.data_ok), 32'(e_dok[0]));
      chk("rnd m1_data_ok", 32'(m1_bus.data_ok), 32'(e_dok[1]));
      chk("rnd m0_rdata", m0_bus.rdata, rd);
      chk("rnd m1_rdata", m1_bus.rdata, rd);
      chk("rnd busy", 32'(busy), 32'(q.size() != 0));
      chk("rnd err_orphan", 32'(err_orphan), 32'(m_orphan));
      // advance model to the state after the coming clock edge
      if (!rst_now) begin
        model_reset();
      end else begin
        if (dok) begin
          if (was_empty) m_orphan = 1;
          else void'(q.pop_front());
        end
        if (e_sreq && aok) begin
          q.push_back(int'(g));
          m_lock = 0;
`ifdef SRAM_ARB_RR_EN
          m_last = g;
`endif
        end else if (e_sreq) begin
          m_lock = 1;
          m_lock_id = g;
        end
      end
      for (int m = 0; m < 2; m++) if (e_aok[m]) p_pend[m] = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
